// File: rtl/game_controller.sv
// Control FSM for the sequence-memory game: sequences the datapath through setup,
// a timed pause, FPGA playback, user entry and checking, and latches the outcome.
module game_controller #(
    parameter int ROUND_GAP = 25000000,
    parameter int GAP_W     = 25
) (
    input  logic       clock_50,
    input  logic       reset,
    input  logic       enter,
    input  logic       end_fpga,
    input  logic       end_user,
    input  logic       end_time,
    input  logic       win,
    input  logic       match,
    output logic       r1,
    output logic       r2,
    output logic       e1,
    output logic       e2,
    output logic       e3,
    output logic       e4,
    output logic       sel,
    output logic       won,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_SETUP  = 4'd1,
        ST_PREP   = 4'd2,
        ST_GAP    = 4'd3,
        ST_SEQ    = 4'd4,
        ST_PLAY   = 4'd5,
        ST_CHECK  = 4'd6,
        ST_NEXT   = 4'd7,
        ST_RESULT = 4'd8
    } state_t;

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(ROUND_GAP - 1);

    state_t           state_q, state_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             won_q, won_d;
    logic             enter_q, enter_d;
    logic             enter_pulse;

    assign enter_pulse = enter & ~enter_q;

    always_ff @(posedge clock_50) begin
        if (!reset) begin
            state_q   <= ST_INIT;
            gap_cnt_q <= '0;
            won_q     <= 1'b0;
            enter_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            won_q     <= won_d;
            enter_q   <= enter_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        won_d     = won_q;
        enter_d   = enter;
        case (state_q)
            ST_INIT: begin
                state_d   = ST_SETUP;
                gap_cnt_d = '0;
                won_d     = 1'b0;
            end
            ST_SETUP: begin
                if (enter_pulse) state_d = ST_PREP;
            end
            ST_PREP: begin
                gap_cnt_d = '0;
                state_d   = ST_GAP;
            end
            ST_GAP: begin
                // The counter is reloaded in PREP, so it never needs to wrap.
                if (gap_cnt_q == GAP_LAST) state_d = ST_SEQ;
                else                       gap_cnt_d = gap_cnt_q + 1'b1;
            end
            ST_SEQ: begin
                if (end_fpga) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                // A finished entry wins over a simultaneous timeout.
                if (end_user) begin
                    state_d = ST_CHECK;
                end else if (end_time) begin
                    state_d = ST_RESULT;
                    won_d   = 1'b0;
                end
            end
            ST_CHECK: begin
                if (!match) begin
                    state_d = ST_RESULT;
                    won_d   = 1'b0;
                end else if (win) begin
                    state_d = ST_RESULT;
                    won_d   = 1'b1;
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                state_d = ST_PREP;
            end
            ST_RESULT: begin
                if (enter_pulse) begin
                    state_d = ST_INIT;
                    won_d   = 1'b0;
                end
            end
            default: begin
                state_d   = ST_INIT;
                gap_cnt_d = '0;
                won_d     = 1'b0;
            end
        endcase
    end

    always_comb begin
        r1  = 1'b0;
        r2  = 1'b0;
        e1  = 1'b0;
        e2  = 1'b0;
        e3  = 1'b0;
        e4  = 1'b0;
        sel = 1'b0;
        case (state_q)
            ST_INIT: begin
                r1 = 1'b1;
                r2 = 1'b1;
            end
            ST_SETUP:  e1  = 1'b1;
            ST_PREP:   r2  = 1'b1;
            ST_GAP:    ;
            ST_SEQ:    e3  = 1'b1;
            ST_PLAY:   e2  = 1'b1;
            ST_CHECK:  ;
            ST_NEXT:   e4  = 1'b1;
            ST_RESULT: sel = 1'b1;
            default: begin
                r1 = 1'b1;
                r2 = 1'b1;
            end
        endcase
    end

    assign won       = won_q;
    assign state_dbg = state_q;

    a_enables_onehot0: assert property (@(posedge clock_50) disable iff (!reset)
        $onehot0({e1, e2, e3, e4}));
    a_r2_excl: assert property (@(posedge clock_50) disable iff (!reset)
        !(r2 && (e2 || e3)));

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller with a short round gap; every vector carries
// a hand-written expected state and outcome.
module tb_game_controller;

    localparam int ROUND_GAP = 4;
    localparam int GAP_W     = 3;

    logic       clock_50;
    logic       reset;
    logic       enter, end_fpga, end_user, end_time, win, match;
    logic       r1, r2, e1, e2, e3, e4, sel, won;
    logic [3:0] state_dbg;

    int n_vec  = 0;
    int n_miss = 0;

    game_controller #(.ROUND_GAP(ROUND_GAP), .GAP_W(GAP_W)) dut (
        .clock_50 (clock_50),
        .reset    (reset),
        .enter    (enter),
        .end_fpga (end_fpga),
        .end_user (end_user),
        .end_time (end_time),
        .win      (win),
        .match    (match),
        .r1       (r1),
        .r2       (r2),
        .e1       (e1),
        .e2       (e2),
        .e3       (e3),
        .e4       (e4),
        .sel      (sel),
        .won      (won),
        .state_dbg(state_dbg)
    );

    initial clock_50 = 1'b0;
    always #10 clock_50 = ~clock_50;

    task automatic tick();
        @(posedge clock_50);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected {r1,r2,e1,e2,e3,e4,sel} per state code, straight from the state table.
    function automatic logic [6:0] cmd_of(input int st);
        case (st)
            0:       return 7'b1100000;
            1:       return 7'b0010000;
            2:       return 7'b0100000;
            3:       return 7'b0000000;
            4:       return 7'b0000100;
            5:       return 7'b0001000;
            6:       return 7'b0000000;
            7:       return 7'b0000010;
            8:       return 7'b0000001;
            default: return 7'b1100000;
        endcase
    endfunction

    task automatic expect_st(input string tag, input int st, input logic exp_won);
        logic [11:0] got, exp;
        got = {state_dbg, r1, r2, e1, e2, e3, e4, sel, won};
        exp = {4'(st), cmd_of(st), exp_won};
        check(tag, 32'(got), 32'(exp));
    endtask

    task automatic press();
        enter = 1'b0;
        tick();
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    // From PREP: expect exactly ROUND_GAP GAP cycles, then SEQ.
    task automatic gap_then_seq(input string tag);
        for (int i = 0; i < ROUND_GAP; i++) begin
            tick();
            expect_st({tag, "_gap"}, 3, 1'b0);
        end
        tick();
        expect_st({tag, "_seq"}, 4, 1'b0);
    endtask

    task automatic pulse_fpga();
        end_fpga = 1'b1;
        tick();
        end_fpga = 1'b0;
    endtask

    initial begin
        int cnt;
        reset = 1'b0; enter = 1'b1;
        end_fpga = 1'b0; end_user = 1'b0; end_time = 1'b0; win = 1'b0; match = 1'b0;

        // 1. Reset with enter held
        repeat (3) tick();
        expect_st("reset", 0, 1'b0);
        reset = 1'b1;
        tick();
        expect_st("setup_after_reset", 1, 1'b0);

        // 2. Held enter gives a single pass through PREP
        enter = 1'b0;
        tick();
        expect_st("setup_hold", 1, 1'b0);
        enter = 1'b1;
        tick();
        expect_st("prep", 2, 1'b0);
        gap_then_seq("r1");
        repeat (4) tick();
        expect_st("seq_hold_enter", 4, 1'b0);
        enter = 1'b0;

        // 3. Winning round
        pulse_fpga();
        expect_st("play", 5, 1'b0);
        tick();
        expect_st("play_hold", 5, 1'b0);
        end_user = 1'b1; match = 1'b1; win = 1'b1;
        tick();
        expect_st("check_win", 6, 1'b0);
        end_user = 1'b0;
        tick();
        expect_st("result_win", 8, 1'b1);
        tick();
        expect_st("result_hold", 8, 1'b1);
        enter = 1'b1;
        tick();
        expect_st("init_after_win", 0, 1'b0);
        tick();
        expect_st("setup_no_repulse", 1, 1'b0);

        // 4. Continuing round: CHECK to SEQ takes 7 cycles
        press();
        expect_st("prep2", 2, 1'b0);
        gap_then_seq("r2");
        pulse_fpga();
        end_user = 1'b1; match = 1'b1; win = 1'b0;
        tick();
        expect_st("check_cont", 6, 1'b0);
        end_user = 1'b0;
        tick();
        expect_st("next", 7, 1'b0);
        tick();
        expect_st("prep_after_next", 2, 1'b0);
        cnt = 2;
        while (state_dbg != 4'd4 && cnt < 20) begin
            tick();
            cnt++;
        end
        check("check_to_seq_cycles", 32'(cnt), 32'd7);

        // Mismatch ends the game as a loss
        pulse_fpga();
        end_user = 1'b1; match = 1'b0;
        tick();
        end_user = 1'b0;
        expect_st("check_miss", 6, 1'b0);
        tick();
        expect_st("result_miss", 8, 1'b0);

        // 5a. Timeout alone
        press();
        expect_st("init_t", 0, 1'b0);
        tick();
        press();
        expect_st("prep_t", 2, 1'b0);
        gap_then_seq("r3");
        pulse_fpga();
        end_time = 1'b1;
        tick();
        end_time = 1'b0;
        expect_st("result_timeout", 8, 1'b0);

        // 5b. end_user beats end_time
        press();
        tick();
        press();
        gap_then_seq("r4");
        pulse_fpga();
        end_time = 1'b1; end_user = 1'b1; match = 1'b1; win = 1'b0;
        tick();
        end_time = 1'b0; end_user = 1'b0;
        expect_st("prio_check", 6, 1'b0);
        tick();
        expect_st("prio_next", 7, 1'b0);

        // 6. Mid-game reset in GAP with gap_cnt=2
        tick();
        expect_st("prep_r5", 2, 1'b0);
        repeat (3) tick();
        expect_st("gap_cnt2", 3, 1'b0);
        reset = 1'b0;
        tick();
        expect_st("midgame_reset", 0, 1'b0);
        reset = 1'b1;
        tick();
        expect_st("setup_after_mid", 1, 1'b0);
        press();
        expect_st("prep_r6", 2, 1'b0);
        gap_then_seq("r6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/game_controller.md
Name: game_controller

Overview:
- Control FSM for the sequence-memory game.
- Drives the datapath command lines (r1, r2, e1–e4, sel) and consumes its status flags (end_fpga, end_user, end_time, win, match).
- Sits directly upstream of the datapath; both blocks share clock_50.
- Inserts a programmable pause before each FPGA sequence playback and latches the final game outcome.

Parameters:
ROUND_GAP, 25000000, clock_50 cycles in GAP before each sequence playback (0.5 s at 50 MHz); legal range ≥1
GAP_W, 25, width of the gap counter; must satisfy 2^GAP_W > ROUND_GAP

Ports:
clock_50  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-low reset
enter  input  1  synchronized, active-high level of the enter key
end_fpga  input  1  FPGA sequence playback complete
end_user  input  1  user entry complete
end_time  input  1  user time limit expired
win  input  1  round counter terminal count (last round reached)
match  input  1  user sequence equals FPGA sequence
r1  output  1  global datapath reset (setup reg, round counter, clock divider)
r2  output  1  round-local datapath reset (time/FPGA counters, FPGA/user regs)
e1  output  1  setup register load enable
e2  output  1  user phase enable (time counter, user reg)
e3  output  1  FPGA playback enable
e4  output  1  round counter increment
sel  output  1  display select: 1 = result screen, 0 = game screen
won  output  1  registered outcome: 1 = game won
state_dbg  output  4  current state code

Behaviour:
- Single clock_50 domain; all flops update on the rising edge.
- reset=0 at an edge → state=INIT, gap_cnt=0, won=0, enter_q=0; this takes priority over every other condition, including mid-game.
- Enter edge detect: enter_q is a registered copy of enter; enter_pulse = enter & ~enter_q. A held key gives exactly one pulse.
- enter_pulse is ignored in every state except SETUP and RESULT.
- Outputs are a Moore decode of the state register. Reset values: r1=1, r2=1, all others 0, state_dbg=0, won=0.

States (state_dbg code: asserted outputs → transition):
- INIT (0): r1=1, r2=1 → SETUP after 1 cycle.
- SETUP (1): e1=1 → PREP on enter_pulse; otherwise hold.
- PREP (2): r2=1 for exactly 1 cycle; gap_cnt←0 → GAP.
- GAP (3): no commands asserted; gap_cnt increments each cycle → SEQ when gap_cnt==ROUND_GAP-1. GAP therefore lasts exactly ROUND_GAP cycles.
- SEQ (4): e3=1 → PLAY when end_fpga=1, sampled at the edge; otherwise hold.
- PLAY (5): e2=1.
  - end_user=1 → CHECK. end_user has priority if end_time is also 1 in the same cycle.
  - else end_time=1 → RESULT, with won←0.
  - else hold.
- CHECK (6): 1 cycle, no commands asserted.
  - match=0 → RESULT, won←0.
  - match=1 & win=1 → RESULT, won←1.
  - match=1 & win=0 → NEXT.
- NEXT (7): e4=1 for exactly 1 cycle → PREP.
- RESULT (8): sel=1; won holds its value → INIT on enter_pulse.
- Undefined codes 9–15 → INIT on the next edge; outputs decode as INIT.

Other rules:
- Exactly one of e1–e4 is high in any cycle, or none.
- r2 is never high in the same cycle as e2 or e3.
- gap_cnt is GAP_W bits and does not wrap: it is reloaded in PREP and compared against ROUND_GAP-1.
- won changes only on the CHECK/PLAY→RESULT transition and on reset/INIT.
- Command outputs change 1 cycle after the status edge that causes the transition (registered state, combinational decode).

Test Plan:
1. Reset: hold reset=0 for 3 cycles with enter=1 → state_dbg=0, r1=r2=1, won=0. Release reset → state_dbg=1, e1=1 on the next edge.
2. Enter edge (ROUND_GAP=4): in SETUP, hold enter=1 for 10 cycles → exactly one pass through PREP (r2 high 1 cycle), then GAP for 4 cycles, then SEQ with e3=1. No second transition while enter stays high.
3. Winning round: in SEQ pulse end_fpga → PLAY (e2=1). Pulse end_user with match=1, win=1 → CHECK for 1 cycle, then RESULT with sel=1, won=1. Enter pulse → INIT with won=0.
4. Continuing round: in CHECK with match=1, win=0 → NEXT (e4 high exactly 1 cycle) → PREP → GAP → SEQ. Total CHECK-to-SEQ is 1+1+ROUND_GAP+... cycles, i.e. 7 cycles with ROUND_GAP=4.
5. Timeout and priority: in PLAY, raise end_time alone → RESULT, won=0. Separately, raise end_time and end_user together with match=1, win=0 → CHECK then NEXT, not RESULT.
6. Mid-game reset: drive reset=0 while in GAP with gap_cnt=2 → INIT on that edge, gap_cnt=0, r1=r2=1. The next run starts a full ROUND_GAP count.
